// File: rtl/cro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF controller.
// Holds the sequencer state encoding and the drain length used by the top level.
package cro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        CMP    = 3'd4,
        DONE   = 3'd5
    } cro_state_e;

    // Cycles the rings stay disabled after the window so in-flight
    // synchronizer edges still reach the counters.
    localparam int DRAIN_CYC = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of an asynchronous ring-oscillator output.
// Two-flop synchronizer, previous-value flop for edge detect, saturating counter.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] count
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic rise;

    assign rise = sync_2 & ~prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= ro_in;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    // Clear wins over counting; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && rise && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cro_puf_ctrl.sv
// Sequences one challenge/response evaluation of a configurable RO PUF pair:
// latch selects, settle, measure for a fixed window, drain, compare, report.
module cro_puf_ctrl
    import cro_puf_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 1024,
    parameter int SETTLE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*N_STAGES-1:0] challenge,
    input  logic                  ro_a,
    input  logic                  ro_b,
    output logic [N_STAGES-1:0]   sel_a,
    output logic [N_STAGES-1:0]   sel_b,
    output logic                  ro_en,
    output logic                  busy,
    output logic                  done,
    output logic                  response,
    output logic                  tie,
    output logic [CNT_W-1:0]      count_a,
    output logic [CNT_W-1:0]      count_b
);

    localparam int TMR_MAX = max_int(max_int(WINDOW, SETTLE), DRAIN_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    cro_state_e       state;
    logic [TMR_W-1:0] timer;
    logic             start_acc;
    logic             cnt_en;

    // Handshake: start is a request sampled only in IDLE; busy is the
    // acknowledge and stays high through the done pulse, so a start seen
    // while busy=1 (including the done cycle) is dropped, not queued.
    assign start_acc = (state == IDLE) && start;
    assign cnt_en    = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_a    <= challenge[N_STAGES-1:0];
                        sel_b    <= challenge[2*N_STAGES-1:N_STAGES];
                        busy     <= 1'b1;
                        response <= 1'b0;
                        tie      <= 1'b0;
                        timer    <= TMR_W'(SETTLE - 1);
                        state    <= CONFIG;
                    end
                end
                CONFIG: begin
                    if (timer == '0) begin
                        ro_en <= 1'b1;
                        timer <= TMR_W'(WINDOW - 1);
                        state <= RUN;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                RUN: begin
                    if (timer == '0) begin
                        ro_en <= 1'b0;
                        timer <= TMR_W'(DRAIN_CYC - 1);
                        state <= DRAIN;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                DRAIN: begin
                    if (timer == '0) begin
                        state <= CMP;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CMP: begin
                    response <= (count_a > count_b);
                    tie      <= (count_a == count_b);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Counters are cleared on the accepting edge so results read 0 from CONFIG entry.
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (cnt_en),
        .ro_in (ro_a),
        .count (count_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (cnt_en),
        .ro_in (ro_b),
        .count (count_b)
    );

endmodule

// File: tb/tb_cro_puf_ctrl.sv
// Directed bench for cro_puf_ctrl: a 16-bit instance and a 4-bit saturating instance,
// each fed by a behavioural ring that toggles every half[i] clocks while ro_en is high.
module tb_cro_puf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [9:0]  challenge = '0;

    logic [4:0]  sel_a, sel_b, sel_a_s, sel_b_s;
    logic        ro_en, busy, done, response, tie;
    logic        ro_en_s, busy_s, done_s, response_s, tie_s;
    logic [15:0] count_a, count_b;
    logic [3:0]  count_a_s, count_b_s;

    // ring[0]/ring[1] feed the main instance, ring[2]/ring[3] the saturating one
    logic [3:0]  ring = '0;
    logic [3:0]  ring_en;
    int          half [4] = '{2, 4, 2, 2};
    int          rcnt [4] = '{0, 0, 0, 0};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ring_en = {ro_en_s, ro_en_s, ro_en, ro_en};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!ring_en[i]) begin
                ring[i] = 1'b0;
                rcnt[i] = 0;
            end else begin
                rcnt[i] = rcnt[i] + 1;
                if (rcnt[i] == half[i]) begin
                    ring[i] = ~ring[i];
                    rcnt[i] = 0;
                end
            end
        end
    end

    cro_puf_ctrl #(.N_STAGES(5), .CNT_W(16), .WINDOW(64), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .ro_a(ring[0]), .ro_b(ring[1]),
        .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .busy(busy), .done(done),
        .response(response), .tie(tie), .count_a(count_a), .count_b(count_b)
    );

    cro_puf_ctrl #(.N_STAGES(5), .CNT_W(4), .WINDOW(64), .SETTLE(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .challenge(challenge),
        .ro_a(ring[2]), .ro_b(ring[3]),
        .sel_a(sel_a_s), .sel_b(sel_b_s), .ro_en(ro_en_s), .busy(busy_s), .done(done_s),
        .response(response_s), .tie(tie_s), .count_a(count_a_s), .count_b(count_b_s)
    );

    // Pulses start for one edge; returns in busy cycle 1 (first cycle after acceptance).
    task automatic start_eval(input logic [9:0] chal);
        @(negedge clk);
        challenge = chal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks forward until done; lat is the busy-cycle index where done is seen.
    task automatic wait_done(input int lat0, output int lat, output int en_cyc);
        lat = lat0;
        en_cyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (ro_en === 1'b1) en_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, ro_en, response, tie} !== 5'b0) begin
            $display("FAIL reset_ctrl: busy/done/ro_en/resp/tie=%b expected 00000",
                     {busy, done, ro_en, response, tie});
            fails++;
        end
        tests++;
        if ({sel_a, sel_b, count_a, count_b} !== 42'b0) begin
            $display("FAIL reset_data: sel_a=%h sel_b=%h count_a=%0d count_b=%0d expected all 0",
                     sel_a, sel_b, count_a, count_b);
            fails++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_select_and_timing();
        int lat, en_cyc;
        half[0] = 2; half[1] = 4;
        start_eval(10'h2A5);
        tests++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_after_start: got %b expected 1", busy); fails++;
        end
        tests++;
        if (sel_a !== 5'h05 || sel_b !== 5'h15) begin
            $display("FAIL sel_latch: sel_a=%h sel_b=%h expected 05 15", sel_a, sel_b); fails++;
        end
        wait_done(1, lat, en_cyc);
        tests++;
        if (lat !== 73) begin
            $display("FAIL latency: done at cycle %0d expected 73", lat); fails++;
        end
        tests++;
        if (en_cyc !== 64) begin
            $display("FAIL ro_en_window: high %0d cycles expected 64", en_cyc); fails++;
        end
        tests++;
        if (count_a !== 16'd16 || count_b !== 16'd8) begin
            $display("FAIL counts_2_4: count_a=%0d count_b=%0d expected 16 8", count_a, count_b);
            fails++;
        end
        tests++;
        if (response !== 1'b1 || tie !== 1'b0) begin
            $display("FAIL resp_a_faster: response=%b tie=%b expected 1 0", response, tie); fails++;
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL done_pulse: done=%b busy=%b after done cycle, expected 0 0", done, busy);
            fails++;
        end
        tests++;
        if (count_a !== 16'd16 || response !== 1'b1) begin
            $display("FAIL result_hold: count_a=%0d response=%b expected 16 1", count_a, response);
            fails++;
        end
    endtask

    task automatic test_tie();
        int lat, en_cyc;
        half[0] = 2; half[1] = 2;
        start_eval(10'h0C3);
        tests++;
        if (count_a !== 16'd0 || response !== 1'b0) begin
            $display("FAIL config_clear: count_a=%0d response=%b expected 0 0", count_a, response);
            fails++;
        end
        wait_done(1, lat, en_cyc);
        tests++;
        if (count_a !== 16'd16 || count_b !== 16'd16) begin
            $display("FAIL counts_equal: count_a=%0d count_b=%0d expected 16 16", count_a, count_b);
            fails++;
        end
        tests++;
        if (tie !== 1'b1 || response !== 1'b0) begin
            $display("FAIL tie_flag: tie=%b response=%b expected 1 0", tie, response); fails++;
        end
    endtask

    task automatic test_start_in_done();
        int lat, en_cyc;
        half[0] = 4; half[1] = 2;
        start_eval(10'h1E7);
        wait_done(1, lat, en_cyc);
        tests++;
        if (count_a !== 16'd8 || count_b !== 16'd16 || response !== 1'b0 || tie !== 1'b0) begin
            $display("FAIL resp_b_faster: a=%0d b=%0d resp=%b tie=%b expected 8 16 0 0",
                     count_a, count_b, response, tie);
            fails++;
        end
        challenge = 10'h3FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || sel_a !== 5'h07 || sel_b !== 5'h0F) begin
            $display("FAIL start_in_done: busy=%b sel_a=%h sel_b=%h expected 0 07 0f",
                     busy, sel_a, sel_b);
            fails++;
        end
    endtask

    task automatic test_start_in_run();
        int lat, en_cyc;
        half[0] = 2; half[1] = 4;
        start_eval(10'h2A5);
        repeat (20) @(negedge clk);
        tests++;
        if (ro_en !== 1'b1) begin
            $display("FAIL in_run: ro_en=%b expected 1 at cycle 21", ro_en); fails++;
        end
        challenge = 10'h3FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (sel_a !== 5'h05 || sel_b !== 5'h15) begin
            $display("FAIL start_in_run_sel: sel_a=%h sel_b=%h expected 05 15", sel_a, sel_b);
            fails++;
        end
        wait_done(22, lat, en_cyc);
        tests++;
        if (lat !== 73 || count_a !== 16'd16 || count_b !== 16'd8 || response !== 1'b1) begin
            $display("FAIL start_in_run_res: lat=%0d a=%0d b=%0d resp=%b expected 73 16 8 1",
                     lat, count_a, count_b, response);
            fails++;
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int cyc;
        half[2] = 2; half[3] = 2;
        @(negedge clk);
        challenge = 10'h155;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1;
        while (done_s !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc !== 73) begin
            $display("FAIL sat_latency: done at cycle %0d expected 73", cyc); fails++;
        end
        tests++;
        if (count_a_s !== 4'd15 || count_b_s !== 4'd15) begin
            $display("FAIL saturate: count_a=%0d count_b=%0d expected 15 15", count_a_s, count_b_s);
            fails++;
        end
        tests++;
        if (tie_s !== 1'b1 || response_s !== 1'b0) begin
            $display("FAIL sat_tie: tie=%b response=%b expected 1 0", tie_s, response_s); fails++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, en_cyc;
        half[0] = 2; half[1] = 4;
        start_eval(10'h2A5);
        repeat (30) @(negedge clk);
        tests++;
        if (ro_en !== 1'b1 || count_a === 16'd0) begin
            $display("FAIL pre_reset: ro_en=%b count_a=%0d expected 1 and nonzero", ro_en, count_a);
            fails++;
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ro_en, busy, done, response, tie} !== 5'b0 || count_a !== 16'd0 ||
            count_b !== 16'd0 || sel_a !== 5'd0 || sel_b !== 5'd0) begin
            $display("FAIL reset_mid_run: ro_en=%b busy=%b a=%0d b=%0d sel_a=%h expected all 0",
                     ro_en, busy, count_a, count_b, sel_a);
            fails++;
        end
        rst = 1'b0;
        start_eval(10'h2A5);
        wait_done(1, lat, en_cyc);
        tests++;
        if (lat !== 73 || count_a !== 16'd16 || count_b !== 16'd8 || response !== 1'b1) begin
            $display("FAIL after_reset: lat=%0d a=%0d b=%0d resp=%b expected 73 16 8 1",
                     lat, count_a, count_b, response);
            fails++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_select_and_timing();
        test_tie();
        test_start_in_done();
        test_start_in_run();
        test_saturation();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
